// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU memory bus: I/O window layout, status bits
// and the address region decode used by both the read and the write port.
package cpu_bus_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned ADDR_W = 16;
   localparam int unsigned OFF_W  = 8;

   localparam logic [7:0] IO_BASE = 8'hFF;

   localparam logic [OFF_W-1:0] OFF_CON_DATA = 8'h00;
   localparam logic [OFF_W-1:0] OFF_CON_STAT = 8'h01;
   localparam logic [OFF_W-1:0] OFF_GPIO     = 8'h02;
   localparam logic [OFF_W-1:0] OFF_CYCLE    = 8'h03;

   localparam int unsigned STAT_EMPTY_BIT = 0;
   localparam int unsigned STAT_FULL_BIT  = 1;
   localparam int unsigned STAT_OVF_BIT   = 2;

   typedef enum logic [1:0] {
      REGION_RAM,
      REGION_IO,
      REGION_NONE
   } region_e;

   // RAM takes priority so a full 64K RAM configuration shadows the I/O page.
   function automatic region_e decode_region(input logic [ADDR_W-1:0] addr,
                                             input int unsigned ram_awidth);
      region_e r;
      r = REGION_NONE;
      if (32'(addr) < (32'd1 << ram_awidth)) begin
         r = REGION_RAM;
      end else if (addr[ADDR_W-1:OFF_W] == IO_BASE) begin
         r = REGION_IO;
      end
      return r;
   endfunction

endpackage

// File: rtl/byte_fifo.sv
// Register-array FIFO with no fall-through; a push while full is accepted
// only when a pop happens in the same cycle.
module byte_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           data_in,
   input  logic                       pop,
   output logic [WIDTH-1:0]           data_out,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == CNT_W'(DEPTH));
   assign empty    = (count == '0);
   assign do_pop   = pop & ~empty;
   assign do_push  = push & (~full | do_pop);
   // Head is masked when empty so the output reads zero out of reset.
   assign data_out = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= data_in;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/cpu_mem_target.sv
// Memory-side responder for the CPU bus: word RAM plus an I/O page with a
// console FIFO, status, GPIO and a cycle counter. Fixed one-cycle read latency.
module cpu_mem_target
   import cpu_bus_pkg::*;
#(
   parameter int unsigned RAM_AWIDTH = 12,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] mem_raddr_i,
   input  logic              mem_rd_i,
   output logic [DATA_W-1:0] mem_rdata_o,
   input  logic [ADDR_W-1:0] mem_waddr_i,
   input  logic [DATA_W-1:0] mem_wdata_i,
   input  logic              mem_wr_i,
   output logic [7:0]        tx_data_o,
   output logic              tx_valid_o,
   input  logic              tx_ready_i,
   output logic [DATA_W-1:0] gpio_o
);

   localparam int unsigned RAM_WORDS = 2 ** RAM_AWIDTH;
   localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1;

   logic [DATA_W-1:0] ram [RAM_WORDS];

   region_e           rd_region;
   region_e           wr_region;
   logic [OFF_W-1:0]  rd_off;
   logic [OFF_W-1:0]  wr_off;
   logic              ram_we;
   logic              io_we;
   logic              con_push;
   logic              stat_wr;
   logic              gpio_wr;
   logic              cycle_wr;
   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CNT_W-1:0]  fifo_count;
   logic              ovf;
   logic              ovf_set;
   logic              ovf_clr;
   logic [DATA_W-1:0] cycle_q;
   logic [DATA_W-1:0] stat_word;
   logic [DATA_W-1:0] rd_value_c;

   assign rd_region = decode_region(mem_raddr_i, RAM_AWIDTH);
   assign wr_region = decode_region(mem_waddr_i, RAM_AWIDTH);
   assign rd_off    = mem_raddr_i[OFF_W-1:0];
   assign wr_off    = mem_waddr_i[OFF_W-1:0];

   assign ram_we   = mem_wr_i & (wr_region == REGION_RAM);
   assign io_we    = mem_wr_i & (wr_region == REGION_IO);
   assign con_push = io_we & (wr_off == OFF_CON_DATA);
   assign stat_wr  = io_we & (wr_off == OFF_CON_STAT);
   assign gpio_wr  = io_we & (wr_off == OFF_GPIO);
   assign cycle_wr = io_we & (wr_off == OFF_CYCLE);

   assign fifo_pop   = tx_valid_o & tx_ready_i;
   assign tx_valid_o = ~fifo_empty;

   // A push is only lost when full and nothing drains in the same cycle.
   assign ovf_set = con_push & fifo_full & ~fifo_pop;
   assign ovf_clr = stat_wr & mem_wdata_i[STAT_OVF_BIT];

   byte_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_con_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (con_push),
      .data_in  (mem_wdata_i[7:0]),
      .pop      (fifo_pop),
      .data_out (tx_data_o),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_count)
   );

   // Status word built straight from the occupancy count.
   always_comb begin
      stat_word                 = '0;
      stat_word[STAT_EMPTY_BIT] = (fifo_count == '0);
      stat_word[STAT_FULL_BIT]  = (fifo_count == CNT_W'(FIFO_DEPTH));
      stat_word[STAT_OVF_BIT]   = ovf;
   end

   // Read decode uses pre-edge state, giving read-before-write on collisions.
   always_comb begin
      rd_value_c = '0;
      unique case (rd_region)
         REGION_RAM: rd_value_c = ram[mem_raddr_i[RAM_AWIDTH-1:0]];
         REGION_IO: begin
            case (rd_off)
               OFF_CON_STAT: rd_value_c = stat_word;
               OFF_GPIO:     rd_value_c = gpio_o;
               OFF_CYCLE:    rd_value_c = cycle_q;
               default:      rd_value_c = '0;
            endcase
         end
         default: rd_value_c = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (ram_we) begin
         ram[mem_waddr_i[RAM_AWIDTH-1:0]] <= mem_wdata_i;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_rdata_o <= '0;
      end else if (mem_rd_i) begin
         mem_rdata_o <= rd_value_c;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gpio_o <= '0;
      end else if (gpio_wr) begin
         gpio_o <= mem_wdata_i;
      end
   end

   // Set has priority over a same-cycle clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf <= 1'b0;
      end else if (ovf_set) begin
         ovf <= 1'b1;
      end else if (ovf_clr) begin
         ovf <= 1'b0;
      end
   end

   // A load counts as that cycle's tick, so the next cycle sees wdata+1.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cycle_q <= '0;
      end else if (cycle_wr) begin
         cycle_q <= mem_wdata_i + DATA_W'(1);
      end else begin
         cycle_q <= cycle_q + DATA_W'(1);
      end
   end

endmodule
